// File: rtl/e203_itcm_dump.sv
// ITCM readback engine: reads a run of 64-bit ITCM words and streams them out
// as little-endian bytes (byte k of a word = bits [8k+7:8k]) over valid/ready.
module e203_itcm_dump #(
    parameter int AW = 13,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   word_cnt,
    output logic          busy,
    output logic          done,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_dout,
    output logic          byte_valid,
    output logic [7:0]    byte_data,
    output logic          byte_last,
    input  logic          byte_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [AW:0]   rem_q;
    logic [DW-1:0] shift_q;
    logic [2:0]    idx_q;
    logic          hs;

    assign hs = byte_valid & byte_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = (word_cnt != '0) ? S_READ : S_DONE;
            end
            S_READ: state_d = S_LOAD;
            S_LOAD: state_d = S_SEND;
            S_SEND: begin
                if (hs && idx_q == 3'd7)
                    state_d = (rem_q != '0) ? S_READ : S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q == S_READ) || (state_q == S_LOAD) || (state_q == S_SEND);
    assign done       = (state_q == S_DONE);
    assign ram_cs     = (state_q == S_READ);
    assign ram_we     = 1'b0;
    assign ram_addr   = addr_q;
    assign byte_valid = (state_q == S_SEND);
    // Gate the data so the port reads zero whenever nothing is offered.
    assign byte_data  = byte_valid ? shift_q[7:0] : 8'h00;
    assign byte_last  = byte_valid && (idx_q == 3'd7) && (rem_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q <= start_addr;
                        rem_q  <= word_cnt;
                    end
                end
                S_LOAD: begin
                    // ram_dout belongs to the READ issued in the previous cycle.
                    shift_q <= ram_dout;
                    idx_q   <= '0;
                    addr_q  <= addr_q + 1'b1;
                    rem_q   <= rem_q - 1'b1;
                end
                S_SEND: begin
                    if (hs) begin
                        shift_q <= shift_q >> 8;
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_e203_itcm_dump.sv
// Directed bench for e203_itcm_dump: RAM model, byte scoreboard, timing checks.
module tb_e203_itcm_dump;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   word_cnt = '0;
    logic          busy, done, ram_cs, ram_we;
    logic [AW-1:0] ram_addr;
    logic [63:0]   ram_dout = '0;
    logic          byte_valid, byte_last;
    logic [7:0]    byte_data;
    logic          byte_ready = 1'b1;

    e203_itcm_dump #(.AW(AW), .DW(64)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .word_cnt(word_cnt), .busy(busy), .done(done), .ram_cs(ram_cs),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_ready(byte_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Image as loaded: word i holds bytes i*8+1 .. i*8+8, LSB first.
    function automatic logic [63:0] word_of(input int i);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(i*8 + k + 1);
        return w;
    endfunction

    always @(posedge clk) if (ram_cs) ram_dout <= word_of(int'(ram_addr));

    // Monitor / scoreboard
    logic [8:0]    exp_q[$];
    int            cyc_n = 0, hs_cnt = 0, valid_cnt = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0;
    int            hs_cyc[$];
    int            cs_cyc[$];
    logic [AW-1:0] cs_addr[$];
    logic          held = 1'b0, held_l = 1'b0;
    logic [7:0]    held_d = '0;
    logic [8:0]    e;

    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 64'(byte_valid), 64'(1));
                check("hold_data",  64'(byte_data),  64'(held_d));
                check("hold_last",  64'(byte_last),  64'(held_l));
            end
            if (byte_valid) begin
                valid_cnt++;
                if (byte_ready) begin
                    hs_cnt++;
                    hs_cyc.push_back(cyc_n);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL extra_byte: observed %0h expected none", byte_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte_data", 64'(byte_data), 64'(e[7:0]));
                        check("byte_last", 64'(byte_last), 64'(e[8]));
                    end
                end
            end
            held   = byte_valid && !byte_ready;
            held_d = byte_data;
            held_l = byte_last;
            if (ram_cs) begin
                cs_cyc.push_back(cyc_n);
                cs_addr.push_back(ram_addr);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc_n;
            end
            if (busy) busy_cnt++;
        end
    end

    // Snapshots taken at the start edge T; cycle T+j is cyc_n == t0 + j.
    int t0, cs0, hs0, done0, busy0, valid0;

    task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] n);
        for (int w = 0; w < int'(n); w++)
            for (int k = 0; k < 8; k++)
                exp_q.push_back({(w == int'(n) - 1 && k == 7), word_of((int'(a) + w) % (1 << AW))[8*k +: 8]});
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; word_cnt = n;
        @(posedge clk);
        t0 = cyc_n; cs0 = cs_cyc.size(); hs0 = hs_cyc.size();
        done0 = done_cnt; busy0 = busy_cnt; valid0 = valid_cnt;
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max, input bit bp);
        bit got = 0;
        int k = 0;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge clk); #1;
            if (done_cnt > done0) got = 1;
            else begin
                @(posedge clk); #1;
                k++;
                byte_ready = bp ? (k % 3 == 0) : 1'b1;
            end
        end
        check("done_timeout", 64'(got), 64'(1));
        byte_ready = 1'b1;
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_cs", 64'(ram_cs), 64'(0));
        check("rst_we", 64'(ram_we), 64'(0));
        check("rst_addr", 64'(ram_addr), 64'(0));
        check("rst_valid", 64'(byte_valid), 64'(0));
        check("rst_data", 64'(byte_data), 64'(0));
        check("rst_last", 64'(byte_last), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Single word, full rate
        do_start('0, 5'd1);
        wait_done(40, 0);
        check("sw_done_rel", 64'(done_cyc - t0), 64'(11));
        check("sw_done_cnt", 64'(done_cnt - done0), 64'(1));
        check("sw_cs_cnt", 64'(cs_cyc.size() - cs0), 64'(1));
        check("sw_cs_rel", 64'(cs_cyc[cs0] - t0), 64'(1));
        check("sw_cs_addr", 64'(cs_addr[cs0]), 64'(0));
        check("sw_hs_cnt", 64'(hs_cyc.size() - hs0), 64'(8));
        check("sw_first_rel", 64'(hs_cyc[hs0] - t0), 64'(3));
        check("sw_last_rel", 64'(hs_cyc[hs0+7] - t0), 64'(10));
        check("sw_q_empty", 64'(exp_q.size()), 64'(0));

        // Backpressure
        do_start('0, 5'd1);
        wait_done(100, 1);
        check("bp_hs_cnt", 64'(hs_cyc.size() - hs0), 64'(8));
        check("bp_q_empty", 64'(exp_q.size()), 64'(0));

        // Multi-word with address wrap
        do_start(4'hF, 5'd2);
        wait_done(60, 0);
        check("wr_cs_cnt", 64'(cs_cyc.size() - cs0), 64'(2));
        check("wr_addr0", 64'(cs_addr[cs0]), 64'(15));
        check("wr_addr1", 64'(cs_addr[cs0+1]), 64'(0));
        check("wr_hs_cnt", 64'(hs_cyc.size() - hs0), 64'(16));
        check("wr_gap", 64'(hs_cyc[hs0+8] - hs_cyc[hs0+7]), 64'(3));
        check("wr_valid_cnt", 64'(valid_cnt - valid0), 64'(16));
        check("wr_q_empty", 64'(exp_q.size()), 64'(0));

        // Zero count
        do_start(4'h3, 5'd0);
        wait_done(10, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("z_done_rel", 64'(done_cyc - t0), 64'(1));
        check("z_busy", 64'(busy_cnt - busy0), 64'(0));
        check("z_cs", 64'(cs_cyc.size() - cs0), 64'(0));
        check("z_valid", 64'(valid_cnt - valid0), 64'(0));

        // Start while busy is ignored
        do_start(4'h3, 5'd2);
        repeat (6) @(posedge clk);
        #1 start = 1'b1; start_addr = 4'h9; word_cnt = 5'd5;
        @(posedge clk); #1 start = 1'b0;
        wait_done(60, 0);
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        check("sb_cs_cnt", 64'(cs_cyc.size() - cs0), 64'(2));
        check("sb_addr0", 64'(cs_addr[cs0]), 64'(3));
        check("sb_addr1", 64'(cs_addr[cs0+1]), 64'(4));
        check("sb_hs_cnt", 64'(hs_cyc.size() - hs0), 64'(16));
        check("sb_done_cnt", 64'(done_cnt - done0), 64'(1));
        check("sb_q_empty", 64'(exp_q.size()), 64'(0));

        // Reset on 3rd byte of word 1 of a 4-word dump
        do_start(4'h6, 5'd4);
        begin
            bit got = 0;
            for (int i = 0; i < 60 && !got; i++) begin
                @(negedge clk); #1;
                if (hs_cnt - hs0 >= 10) got = 1;
            end
            check("rm_reach_timeout", 64'(got), 64'(1));
        end
        @(posedge clk); #1;
        check("rm_3rd_byte", 64'(byte_data), 64'(word_of(7)[23:16]));
        rst = 1'b1; byte_ready = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        check("rm_busy", 64'(busy), 64'(0));
        check("rm_done", 64'(done), 64'(0));
        check("rm_cs", 64'(ram_cs), 64'(0));
        check("rm_addr", 64'(ram_addr), 64'(0));
        check("rm_valid", 64'(byte_valid), 64'(0));
        check("rm_data", 64'(byte_data), 64'(0));
        check("rm_last", 64'(byte_last), 64'(0));
        @(posedge clk); #1 rst = 1'b0; byte_ready = 1'b1;
        valid0 = valid_cnt;
        repeat (6) @(posedge clk);
        @(negedge clk); #1;
        check("rm_no_done", 64'(done_cnt - done0), 64'(0));
        check("rm_no_bytes", 64'(valid_cnt - valid0), 64'(0));
        exp_q.delete();

        // Fresh dump after reset
        do_start(4'h5, 5'd2);
        wait_done(60, 0);
        check("fr_hs_cnt", 64'(hs_cyc.size() - hs0), 64'(16));
        check("fr_addr0", 64'(cs_addr[cs0]), 64'(5));
        check("fr_q_empty", 64'(exp_q.size()), 64'(0));

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
